// File: rtl/pic_priority_engine.sv
// Registered 8259A-style priority engine with in-service tracking, rotation, the INTA
// handshake and EOI processing. Arbitration sees the ISR and pointer after any same-cycle EOI.
module pic_priority_engine #(
   parameter  int NUM_IRQ = 8,
   localparam int LEVEL_W = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_IRQ-1:0] irq_request,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               special_mask_mode,
   input  logic               special_fully_nested,
   input  logic               auto_eoi_mode,
   input  logic               rotate_on_aeoi,
   input  logic               ack,
   input  logic               eoi_nonspecific,
   input  logic               eoi_specific,
   input  logic               eoi_rotate,
   input  logic               set_priority,
   input  logic [LEVEL_W-1:0] eoi_level,
   output logic               int_out,
   output logic [LEVEL_W-1:0] ack_level,
   output logic               ack_spurious,
   output logic [NUM_IRQ-1:0] ack_clear,
   output logic [NUM_IRQ-1:0] in_service,
   output logic [LEVEL_W-1:0] lowest_priority
);

   localparam logic [LEVEL_W-1:0] MAX_LEVEL = LEVEL_W'(NUM_IRQ - 1);

   typedef enum logic [1:0] {IDLE, PENDING, ACKED} state_t;

   typedef struct packed {
      logic               found;
      logic [LEVEL_W-1:0] level;
   } pick_t;

   state_t             state;
   pick_t              ns_pick;
   pick_t              win;
   logic               eoi_done;
   logic [LEVEL_W-1:0] eoi_target;
   logic [NUM_IRQ-1:0] isr_eoi;
   logic [LEVEL_W-1:0] ptr_eoi;
   logic [NUM_IRQ-1:0] candidates;
   logic [NUM_IRQ-1:0] blocking;
   logic [NUM_IRQ-1:0] win_onehot;

   // Scan from the highest level (pointer+1) downwards; power-of-two width makes the wrap free.
   function automatic pick_t first_set(input logic [NUM_IRQ-1:0] vec,
                                       input logic [LEVEL_W-1:0] ptr);
      pick_t              p;
      logic [LEVEL_W-1:0] lvl;
      p = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         lvl = ptr + LEVEL_W'(i + 1);
         if (!p.found && vec[lvl]) begin
            p.found = 1'b1;
            p.level = lvl;
         end
      end
      return p;
   endfunction

   // Highest candidate above the first blocking level; SFNM also admits that level itself.
   function automatic pick_t arbitrate(input logic [NUM_IRQ-1:0] cand,
                                       input logic [NUM_IRQ-1:0] blk,
                                       input logic [LEVEL_W-1:0] ptr,
                                       input logic               sfnm);
      pick_t              p;
      logic               stop;
      logic [LEVEL_W-1:0] lvl;
      p    = '0;
      stop = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         lvl = ptr + LEVEL_W'(i + 1);
         if (!stop) begin
            if (blk[lvl]) begin
               stop = 1'b1;
               if (sfnm && cand[lvl]) begin
                  p.found = 1'b1;
                  p.level = lvl;
               end
            end else if (cand[lvl]) begin
               stop    = 1'b1;
               p.found = 1'b1;
               p.level = lvl;
            end
         end
      end
      return p;
   endfunction

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      ns_pick    = first_set(in_service, lowest_priority);
      eoi_done   = 1'b0;
      eoi_target = '0;
      isr_eoi    = in_service;
      ptr_eoi    = lowest_priority;

      if (eoi_specific) begin
         eoi_done   = 1'b1;
         eoi_target = eoi_level;
      end else if (eoi_nonspecific && ns_pick.found) begin
         eoi_done   = 1'b1;
         eoi_target = ns_pick.level;
      end
      if (eoi_done) isr_eoi[eoi_target] = 1'b0;

      if (set_priority) ptr_eoi = eoi_level;
      if (eoi_done && eoi_rotate) ptr_eoi = eoi_target;

      candidates = irq_request & ~irq_mask;
      blocking   = special_mask_mode ? (isr_eoi & ~irq_mask) : isr_eoi;
      win        = arbitrate(candidates, blocking, ptr_eoi, special_fully_nested);
      win_onehot = NUM_IRQ'(1) << win.level;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         int_out         <= 1'b0;
         ack_level       <= '0;
         ack_spurious    <= 1'b0;
         ack_clear       <= '0;
         in_service      <= '0;
         lowest_priority <= MAX_LEVEL;
      end else begin
         in_service      <= isr_eoi;
         lowest_priority <= ptr_eoi;
         ack_clear       <= '0;
         case (state)
            IDLE: begin
               if (ack) begin
                  ack_level    <= MAX_LEVEL;
                  ack_spurious <= 1'b1;
               end else if (win.found) begin
                  state   <= PENDING;
                  int_out <= 1'b1;
               end
            end
            PENDING: begin
               if (ack) begin
                  state   <= ACKED;
                  int_out <= 1'b0;
                  if (win.found) begin
                     ack_level    <= win.level;
                     ack_spurious <= 1'b0;
                     ack_clear    <= win_onehot;
                     if (!auto_eoi_mode) in_service <= isr_eoi | win_onehot;
                     else if (rotate_on_aeoi) lowest_priority <= win.level;
                  end else begin
                     ack_level    <= MAX_LEVEL;
                     ack_spurious <= 1'b1;
                  end
               end else if (!win.found) begin
                  state   <= IDLE;
                  int_out <= 1'b0;
               end
            end
            ACKED: state <= IDLE;
            default: begin
               state   <= IDLE;
               int_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_priority_engine.sv
// Bench for pic_priority_engine: an 8-channel and a 16-channel instance. Acknowledge
// responses are checked by per-instance monitors against scoreboard queues.
module tb_pic_priority_engine;

   typedef struct {
      logic [3:0]  level;
      logic        spur;
      logic [15:0] clr;
      logic [15:0] isr;
      logic [3:0]  lp;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        smm, sfnm, aeoi, rao;
   logic        eoi_ns, eoi_sp, eoi_rot, set_pri;
   logic        ack8, ack16;
   logic [7:0]  req8, mask8, clr8, isr8;
   logic [15:0] req16, mask16, clr16, isr16;
   logic [2:0]  lvl8, alvl8, lp8;
   logic [3:0]  lvl16, alvl16, lp16;
   logic        int8, int16, spur8, spur16;

   int   checks   = 0;
   int   failures = 0;
   exp_t q8[$];
   exp_t q16[$];

   always #5 clock = ~clock;

   pic_priority_engine #(.NUM_IRQ(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .irq_request(req8), .irq_mask(mask8),
      .special_mask_mode(smm), .special_fully_nested(sfnm), .auto_eoi_mode(aeoi),
      .rotate_on_aeoi(rao), .ack(ack8), .eoi_nonspecific(eoi_ns), .eoi_specific(eoi_sp),
      .eoi_rotate(eoi_rot), .set_priority(set_pri), .eoi_level(lvl8), .int_out(int8),
      .ack_level(alvl8), .ack_spurious(spur8), .ack_clear(clr8), .in_service(isr8),
      .lowest_priority(lp8));

   pic_priority_engine #(.NUM_IRQ(16)) dut16 (
      .clock(clock), .reset_n(reset_n), .irq_request(req16), .irq_mask(mask16),
      .special_mask_mode(smm), .special_fully_nested(sfnm), .auto_eoi_mode(aeoi),
      .rotate_on_aeoi(rao), .ack(ack16), .eoi_nonspecific(eoi_ns), .eoi_specific(eoi_sp),
      .eoi_rotate(eoi_rot), .set_priority(set_pri), .eoi_level(lvl16), .int_out(int16),
      .ack_level(alvl16), .ack_spurious(spur16), .ack_clear(clr16), .in_service(isr16),
      .lowest_priority(lp16));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic exp_t mk(input logic [3:0] level, input logic spur, input logic [15:0] clr,
                               input logic [15:0] isr, input logic [3:0] lp);
      exp_t e;
      e.level = level; e.spur = spur; e.clr = clr; e.isr = isr; e.lp = lp;
      return e;
   endfunction

   // Monitors: the cycle after an ack edge, the DUT must present the acknowledge response.
   initial begin : mon8
      logic was;
      exp_t e;
      forever begin
         @(posedge clock);
         was = ack8;
         @(negedge clock);
         if (was) begin
            if (q8.size() == 0) check("sb8_unexpected_ack", 1, 0);
            else begin
               e = q8.pop_front();
               check("ack8_level", {29'd0, alvl8}, {28'd0, e.level});
               check("ack8_spurious", {31'd0, spur8}, {31'd0, e.spur});
               check("ack8_clear", {24'd0, clr8}, {16'd0, e.clr});
               check("ack8_isr", {24'd0, isr8}, {16'd0, e.isr});
               check("ack8_lowest", {29'd0, lp8}, {28'd0, e.lp});
               check("ack8_int_drop", {31'd0, int8}, 0);
            end
         end
      end
   end

   initial begin : mon16
      logic was;
      exp_t e;
      forever begin
         @(posedge clock);
         was = ack16;
         @(negedge clock);
         if (was) begin
            if (q16.size() == 0) check("sb16_unexpected_ack", 1, 0);
            else begin
               e = q16.pop_front();
               check("ack16_level", {28'd0, alvl16}, {28'd0, e.level});
               check("ack16_spurious", {31'd0, spur16}, {31'd0, e.spur});
               check("ack16_clear", {16'd0, clr16}, {16'd0, e.clr});
               check("ack16_isr", {16'd0, isr16}, {16'd0, e.isr});
               check("ack16_lowest", {28'd0, lp16}, {28'd0, e.lp});
               check("ack16_int_drop", {31'd0, int16}, 0);
            end
         end
      end
   end

   // One ack cycle, then the ACKED cycle; the IRR bit is cleared as edge-mode logic would.
   task automatic do_ack8(input exp_t e);
      q8.push_back(e);
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
      req8 = req8 & ~e.clr[7:0];
      tick();
      check("ack8_clear_one_cycle", {24'd0, clr8}, 0);
   endtask

   task automatic do_ack16(input exp_t e);
      q16.push_back(e);
      ack16 = 1'b1;
      tick();
      ack16 = 1'b0;
      req16 = req16 & ~e.clr;
      tick();
      check("ack16_clear_one_cycle", {16'd0, clr16}, 0);
   endtask

   task automatic wait_int16(input string name);
      int n = 0;
      while (!int16 && n < 10) begin
         tick();
         n++;
      end
      check(name, {31'd0, int16}, 1);
   endtask

   task automatic pulse_eoi(input logic ns, input logic sp, input logic rot, input logic sprio,
                            input logic [2:0] l8);
      eoi_ns = ns; eoi_sp = sp; eoi_rot = rot; set_pri = sprio; lvl8 = l8;
      tick();
      eoi_ns = 1'b0; eoi_sp = 1'b0; eoi_rot = 1'b0; set_pri = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n = 1'b0;
      {smm, sfnm, aeoi, rao, eoi_ns, eoi_sp, eoi_rot, set_pri, ack8, ack16} = '0;
      req8 = '0; mask8 = '0; req16 = '0; mask16 = '0; lvl8 = '0; lvl16 = '0;
      repeat (2) tick();
      check("rst_int_out", {31'd0, int8}, 0);
      check("rst_lowest8", {29'd0, lp8}, 32'd7);
      check("rst_lowest16", {28'd0, lp16}, 32'd15);
      check("rst_isr8", {24'd0, isr8}, 0);
      check("rst_ack_level", {29'd0, alvl8}, 0);
      check("rst_spurious", {31'd0, spur8}, 0);
      check("rst_ack_clear", {24'd0, clr8}, 0);
      reset_n = 1'b1;
      tick();

      // IR2 wins over IR5 with default priority.
      req8 = 8'h24;
      tick();
      check("basic_int_latency", {31'd0, int8}, 1);
      do_ack8(mk(4'd2, 1'b0, 16'h04, 16'h04, 4'd7));
      req8 = 8'h00;

      // Lower level blocked by IR2 in service; higher IR1 nests.
      req8 = 8'h10;
      repeat (2) tick();
      check("blocked_by_isr", {31'd0, int8}, 0);
      req8 = 8'h02;
      tick();
      check("nested_int", {31'd0, int8}, 1);
      do_ack8(mk(4'd1, 1'b0, 16'h02, 16'h06, 4'd7));
      req8 = 8'h00;

      // Non-specific rotating EOI clears IR1 and makes it lowest.
      pulse_eoi(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      check("nseoi_isr", {24'd0, isr8}, 32'h04);
      check("nseoi_rotate", {29'd0, lp8}, 32'd1);
      pulse_eoi(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
      check("seoi_isr", {24'd0, isr8}, 0);
      req8 = 8'h09;
      tick();
      check("rotated_int", {31'd0, int8}, 1);
      do_ack8(mk(4'd3, 1'b0, 16'h08, 16'h08, 4'd1));
      req8 = 8'h00;

      pulse_eoi(1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
      pulse_eoi(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
      check("set_priority_ptr", {29'd0, lp8}, 32'd7);
      check("set_priority_isr", {24'd0, isr8}, 0);
      req8 = 8'h04;
      tick();
      do_ack8(mk(4'd2, 1'b0, 16'h04, 16'h04, 4'd7));

      // Special mask mode: masked in-service IR2 no longer blocks IR5.
      mask8 = 8'h04; smm = 1'b1; req8 = 8'h20;
      tick();
      check("smm_int", {31'd0, int8}, 1);
      do_ack8(mk(4'd5, 1'b0, 16'h20, 16'h24, 4'd7));
      pulse_eoi(1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
      smm = 1'b0; req8 = 8'h20;
      repeat (2) tick();
      check("smm_off_blocked", {31'd0, int8}, 0);

      // Fully nested: IR2 in service may be re-interrupted by IR2.
      mask8 = 8'h00; sfnm = 1'b1; req8 = 8'h04;
      tick();
      check("sfnm_int", {31'd0, int8}, 1);
      do_ack8(mk(4'd2, 1'b0, 16'h04, 16'h04, 4'd7));
      sfnm = 1'b0; req8 = 8'h00;

      pulse_eoi(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      check("nseoi_norot_isr", {24'd0, isr8}, 0);
      pulse_eoi(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      check("nseoi_empty_ptr", {29'd0, lp8}, 32'd7);

      // Request vanishes before ack, then withdrawn in the ack cycle.
      req8 = 8'h01;
      tick();
      check("vanish_int_up", {31'd0, int8}, 1);
      req8 = 8'h00;
      tick();
      check("vanish_int_down", {31'd0, int8}, 0);
      req8 = 8'h01;
      tick();
      check("withdraw_int_up", {31'd0, int8}, 1);
      req8 = 8'h00;
      do_ack8(mk(4'd7, 1'b1, 16'h00, 16'h00, 4'd7));
      do_ack8(mk(4'd7, 1'b1, 16'h00, 16'h00, 4'd7));

      // Reset during the ack_clear pulse abandons it.
      req8 = 8'h01;
      tick();
      q8.push_back(mk(4'd0, 1'b0, 16'h01, 16'h01, 4'd7));
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
      req8 = 8'h00;
      #2 reset_n = 1'b0;
      #1;
      check("midreset_clear", {24'd0, clr8}, 0);
      check("midreset_isr", {24'd0, isr8}, 0);
      do_reset();

      // 16-channel instance: AEOI with rotation.
      check("rst16_lowest", {28'd0, lp16}, 32'd15);
      aeoi = 1'b1; rao = 1'b1; req16 = 16'h8001;
      tick();
      check("aeoi_int", {31'd0, int16}, 1);
      do_ack16(mk(4'd0, 1'b0, 16'h0001, 16'h0000, 4'd0));
      wait_int16("aeoi_int2");
      do_ack16(mk(4'd15, 1'b0, 16'h8000, 16'h0000, 4'd15));
      aeoi = 1'b0; rao = 1'b0;
      req16 = 16'h0002;
      wait_int16("isr16_int");
      do_ack16(mk(4'd1, 1'b0, 16'h0002, 16'h0002, 4'd15));

      // Ack and specific EOI in one cycle: both effects land.
      req16 = 16'h0001;
      wait_int16("ack_eoi_int");
      q16.push_back(mk(4'd0, 1'b0, 16'h0001, 16'h0001, 4'd15));
      ack16 = 1'b1; eoi_sp = 1'b1; lvl16 = 4'd1;
      tick();
      ack16 = 1'b0; eoi_sp = 1'b0; req16 = 16'h0000;
      tick();
      check("ack_eoi_isr", {16'd0, isr16}, 32'h0001);

      // Same level acked and EOI-cleared in one cycle ends set.
      sfnm = 1'b1; req16 = 16'h0001;
      wait_int16("same_level_int");
      q16.push_back(mk(4'd0, 1'b0, 16'h0001, 16'h0001, 4'd15));
      ack16 = 1'b1; eoi_sp = 1'b1; lvl16 = 4'd0;
      tick();
      ack16 = 1'b0; eoi_sp = 1'b0; req16 = 16'h0000; sfnm = 1'b0;
      tick();
      check("same_level_isr", {16'd0, isr16}, 32'h0001);

      check("sb8_drained", q8.size(), 0);
      check("sb16_drained", q16.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
